// File: rtl/mem_stage.sv
// mem_stage: memory stage of the 5-stage MIPS pipeline.
// Holds the data memory, performs byte/halfword/word stores at the clock edge,
// extracts and extends load data combinationally, and registers everything
// into the M/W pipeline register for writeback.
// The memory is built from individually reset flops because every word must
// clear asynchronously on reset, which a block RAM cannot do.
module mem_stage #(
   parameter int DM_WORDS = 1024,
   parameter int DM_ABITS = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Instr_in_M,
   input  logic [31:0] ALU_Out_in_M,
   input  logic [31:0] WriteData_in_M,
   input  logic [4:0]  WriteReg_in_M,
   input  logic [31:0] PC4_in_M,
   output logic [31:0] Instr_out_W,
   output logic [31:0] ALU_Out_out_W,
   output logic [31:0] Data_out_dm_out_W,
   output logic [4:0]  WriteReg_out_W,
   output logic [31:0] PC4_out_W
);

   // Opcodes handled by this stage
   localparam logic [5:0] OP_SW  = 6'b101011;
   localparam logic [5:0] OP_SH  = 6'b101001;
   localparam logic [5:0] OP_SB  = 6'b101000;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_LH  = 6'b100001;
   localparam logic [5:0] OP_LHU = 6'b100101;
   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LBU = 6'b100100;

   logic [5:0]          opcode;
   logic [DM_ABITS-1:0] word_idx;
   logic [1:0]          lane;

   // Higher address bits are dropped, so addresses wrap modulo DM_WORDS*4
   assign opcode   = Instr_in_M[31:26];
   assign word_idx = ALU_Out_in_M[DM_ABITS+1:2];
   assign lane     = ALU_Out_in_M[1:0];

   // Decoded instruction class
   logic is_sw, is_sh, is_sb;
   logic is_lw, is_lh, is_lhu, is_lb, is_lbu;

   // Opcode decode into one-hot load/store flags
   always_comb begin
      is_sw  = 1'b0;
      is_sh  = 1'b0;
      is_sb  = 1'b0;
      is_lw  = 1'b0;
      is_lh  = 1'b0;
      is_lhu = 1'b0;
      is_lb  = 1'b0;
      is_lbu = 1'b0;
      case (opcode)
         OP_SW:   is_sw  = 1'b1;
         OP_SH:   is_sh  = 1'b1;
         OP_SB:   is_sb  = 1'b1;
         OP_LW:   is_lw  = 1'b1;
         OP_LH:   is_lh  = 1'b1;
         OP_LHU:  is_lhu = 1'b1;
         OP_LB:   is_lb  = 1'b1;
         OP_LBU:  is_lbu = 1'b1;
         default: ;
      endcase
   end

   // Store path: byte enables and lane-replicated write data
   logic [3:0]  st_be;
   logic [31:0] st_data;

   // Replicating the source data across lanes lets each byte simply take its
   // own slice; the byte enables decide which lanes actually change.
   always_comb begin
      st_be   = 4'b0000;
      st_data = 32'h0;
      if (is_sw) begin
         st_be   = 4'b1111;
         st_data = WriteData_in_M;
      end else if (is_sh) begin
         st_be   = lane[1] ? 4'b1100 : 4'b0011;
         st_data = {2{WriteData_in_M[15:0]}};
      end else if (is_sb) begin
         st_be   = 4'b0001 << lane;
         st_data = {4{WriteData_in_M[7:0]}};
      end
   end

   // Read-side view of every word, fed by the per-word storage below
   logic [31:0] mem_rd [DM_WORDS];

   generate
      for (genvar gi = 0; gi < DM_WORDS; gi++) begin : g_word
         logic [31:0] word_q;
         logic        word_sel;

         assign word_sel  = (word_idx == DM_ABITS'(gi));
         assign mem_rd[gi] = word_q;

         // Word storage: cleared by reset, byte-masked write when addressed
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               word_q <= 32'h0;
            end else if (word_sel) begin
               for (int b = 0; b < 4; b++) begin
                  if (st_be[b]) begin
                     word_q[8*b +: 8] <= st_data[8*b +: 8];
                  end
               end
            end
         end
      end
   endgenerate

   // Load path
   logic [31:0] rd_word;
   logic [7:0]  rd_byte;
   logic [15:0] rd_half;
   logic [31:0] ld_data;

   assign rd_word = mem_rd[word_idx];

   // Lane/halfword selection; addr[0] is ignored for halfwords
   always_comb begin
      rd_byte = rd_word[8*lane +: 8];
      rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
   end

   // Sign/zero extension; non-loads present zero
   always_comb begin
      ld_data = 32'h0;
      if (is_lw) begin
         ld_data = rd_word;
      end else if (is_lh) begin
         ld_data = {{16{rd_half[15]}}, rd_half};
      end else if (is_lhu) begin
         ld_data = {16'h0, rd_half};
      end else if (is_lb) begin
         ld_data = {{24{rd_byte[7]}}, rd_byte};
      end else if (is_lbu) begin
         ld_data = {24'h0, rd_byte};
      end
   end

   // M/W pipeline register
   logic [31:0] instr_q,    instr_d;
   logic [31:0] alu_out_q,  alu_out_d;
   logic [31:0] dm_data_q,  dm_data_d;
   logic [4:0]  write_reg_q, write_reg_d;
   logic [31:0] pc4_q,      pc4_d;

   // Next-state of the pipeline register: always the current M-stage values
   always_comb begin
      instr_d     = Instr_in_M;
      alu_out_d   = ALU_Out_in_M;
      dm_data_d   = ld_data;
      write_reg_d = WriteReg_in_M;
      pc4_d       = PC4_in_M;
   end

   // Pipeline register: zero (a nop) on reset, capture every edge otherwise
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instr_q     <= 32'h0;
         alu_out_q   <= 32'h0;
         dm_data_q   <= 32'h0;
         write_reg_q <= 5'd0;
         pc4_q       <= 32'h0;
      end else begin
         instr_q     <= instr_d;
         alu_out_q   <= alu_out_d;
         dm_data_q   <= dm_data_d;
         write_reg_q <= write_reg_d;
         pc4_q       <= pc4_d;
      end
   end

   assign Instr_out_W       = instr_q;
   assign ALU_Out_out_W     = alu_out_q;
   assign Data_out_dm_out_W = dm_data_q;
   assign WriteReg_out_W    = write_reg_q;
   assign PC4_out_W         = pc4_q;

endmodule
